// File: rtl/booth_multiplier_unit_pkg.sv
// Shared multiply/divide unit definitions: FSM states, Booth digit encoding
// and the digit-count helper used to size the multiplier's control logic.
package mdu_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } stateT;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } boothDigitT;

  // Operands are extended by two bits, which gives width/2 + 1 radix-4 digits.
  function automatic int unsigned boothDigitCount(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Radix-4 recoding of the overlapping triplet {b(2i+1), b(2i), b(2i-1)}.
  function automatic boothDigitT decodeTriplet(input logic [2:0] triplet);
    unique case (triplet)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_multiplier_unit_if.sv
// Handshake and operand/result bundle for booth_multiplier_unit.
//   master: drives start/usigned/multiplicand/multiplier, observes results.
//   slave : the multiplier itself.
interface booth_multiplier_unit_if #(
  parameter int unsigned parallelism = 32
);
  logic                   start;
  logic                   usigned;
  logic [parallelism-1:0] multiplicand;
  logic [parallelism-1:0] multiplier;
  logic                   busy;
  logic                   done;
  logic [parallelism-1:0] productH;
  logic [parallelism-1:0] productL;

  modport master (
    output start, usigned, multiplicand, multiplier,
    input  busy, done, productH, productL
  );

  modport slave (
    input  start, usigned, multiplicand, multiplier,
    output busy, done, productH, productL
  );
endinterface

// File: rtl/booth_multiplier_unit_pp_gen.sv
// Combinational radix-4 Booth partial-product generator.
//   triplet        : {b(2i+1), b(2i), b(2i-1)} of the extended multiplier
//   mcandExt       : multiplicand already extended to parallelism+2 bits
//   partialProduct : selected multiple, sign-extended to accumulator width;
//                    negative digits are returned as the one's complement
//   negCin         : +1 completing the two's-complement negation
module booth_pp_gen
  import mdu_pkg::*;
#(
  parameter int unsigned parallelism = 32
) (
  input  logic [2:0]               triplet,
  input  logic [parallelism+1:0]   mcandExt,
  output logic [2*parallelism+3:0] partialProduct,
  output logic                     negCin
);
  localparam int unsigned EW = parallelism + 2;
  localparam int unsigned AW = 2 * parallelism + 4;

  boothDigitT digit;
  logic [AW-1:0] mcandWide;

  assign digit     = decodeTriplet(triplet);
  assign mcandWide = {{(AW - EW){mcandExt[EW-1]}}, mcandExt};

  always_comb begin
    partialProduct = '0;
    negCin         = 1'b0;
    unique case (digit)
      POS1: partialProduct = mcandWide;
      POS2: partialProduct = mcandWide << 1;
      NEG1: begin
        partialProduct = ~mcandWide;
        negCin         = 1'b1;
      end
      NEG2: begin
        partialProduct = ~(mcandWide << 1);
        negCin         = 1'b1;
      end
      default: partialProduct = '0;
    endcase
  end
endmodule

// File: rtl/booth_multiplier_unit.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.start  : request, sampled only in IDLE together with usigned and operands
//   bus.busy   : operation in progress
//   bus.done   : one-cycle pulse when productH/productL update
//   bus.productH/productL : upper/lower half of the 2*parallelism-bit product,
//                           held between operations
module booth_multiplier_unit
  import mdu_pkg::*;
#(
  parameter int unsigned parallelism = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  booth_multiplier_unit_if.slave bus
);
  localparam int unsigned P  = parallelism;
  localparam int unsigned EW = P + 2;
  localparam int unsigned AW = 2 * P + 4;
  localparam int unsigned N  = boothDigitCount(P);
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  stateT state, nextState;

  logic [EW-1:0] mcandReg;
  logic [EW:0]   mplierReg;
  logic [AW-1:0] accReg;
  logic [CW-1:0] count;
  logic          doneReg;
  logic [P-1:0]  productHReg;
  logic [P-1:0]  productLReg;

  logic [EW-1:0] mcandExt;
  logic [EW-1:0] mplierExt;
  logic [AW-1:0] partialProduct;
  logic          negCin;
  logic [AW-1:0] ppTerm;
  logic [AW-1:0] accNext;
  logic          lastDigit;
  logic          load;

  // Operand extension: zero for unsigned, sign for signed.
  assign mcandExt  = bus.usigned ? {2'b00, bus.multiplicand}
                                 : {{2{bus.multiplicand[P-1]}}, bus.multiplicand};
  assign mplierExt = bus.usigned ? {2'b00, bus.multiplier}
                                 : {{2{bus.multiplier[P-1]}}, bus.multiplier};

  // The multiplier register shifts right two places per digit, so the
  // current triplet is always its low three bits.
  booth_pp_gen #(
    .parallelism(P)
  ) ppGen (
    .triplet       (mplierReg[2:0]),
    .mcandExt      (mcandReg),
    .partialProduct(partialProduct),
    .negCin        (negCin)
  );

  // Carry-in is folded in before the shift; identical modulo 2^AW.
  assign ppTerm    = partialProduct + AW'(negCin);
  assign accNext   = accReg + (ppTerm << {count, 1'b0});
  assign lastDigit = (count == LAST_DIGIT);

  always_comb begin
    nextState = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        if (lastDigit) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcandReg    <= '0;
      mplierReg   <= '0;
      accReg      <= '0;
      count       <= '0;
      doneReg     <= 1'b0;
      productHReg <= '0;
      productLReg <= '0;
    end else begin
      state   <= nextState;
      doneReg <= 1'b0;
      if (load) begin
        mcandReg  <= mcandExt;
        mplierReg <= {mplierExt, 1'b0};
        accReg    <= '0;
        count     <= '0;
      end else if (state == RUN) begin
        accReg    <= accNext;
        mplierReg <= mplierReg >> 2;
        count     <= count + 1'b1;
        if (lastDigit) begin
          productHReg <= accNext[2*P-1:P];
          productLReg <= accNext[P-1:0];
          doneReg     <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = doneReg;
  assign bus.productH = productHReg;
  assign bus.productL = productLReg;
endmodule

// File: doc/booth_multiplier_unit.md
Name: booth_multiplier_unit

Overview:
Sequential radix-4 Booth multiplier. It is the companion to the iterative divider in the multiply/division unit and performs the inverse operation: it takes two operands and produces a 2*parallelism-bit product split into high and low words. Operation is controlled by a start/done handshake. One Booth digit is processed per clock, and an internal iteration counter tracks progress.

Parameters:
parallelism, 32, operand width in bits. Must be even and at least 4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new multiplication. Sampled only in IDLE.
usigned  input  1  1 = both operands unsigned, 0 = both two's-complement. Sampled with start.
multiplicand  input  parallelism  operand A. Sampled with start.
multiplier  input  parallelism  operand B. Sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when the product registers update.
productH  output  parallelism  upper half of the product.
productL  output  parallelism  lower half of the product.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; busy=0; done=0; productH=0; productL=0; accumulator, operand registers and counter all 0. Reset mid-operation aborts the operation with no done pulse.
- Operand extension, applied at the start edge:
  - Unsigned: zero-extend both operands to parallelism+2 bits.
  - Signed: sign-extend both operands to parallelism+2 bits.
  - An implied 0 is appended below the multiplier LSB.
  - This gives N = parallelism/2 + 1 Booth digits (17 for the default).
- Booth recoding: each digit is decoded from the overlapping bit triplet {b(2i+1), b(2i), b(2i-1)} into {0, +A, +2A, -A, -2A}.
  - Negation is done as ~x plus carry-in 1.
  - Partial products are sign-extended to the accumulator width.
- Accumulator: 2*parallelism+4 bits, two's complement. Iteration i adds the partial product shifted left by 2i. Overflow beyond the accumulator MSB is discarded.
- State machine:
  - IDLE: busy=0. A start edge latches the operands, clears the accumulator, sets count=0 and moves to RUN.
  - RUN: busy=1. Each edge processes digit count, then count increments.
  - On the edge that processes digit N-1:
    - productH <= acc[2P-1:P] and productL <= acc[P-1:0], where P = parallelism.
    - done <= 1 and state <= IDLE.
- Latency: start is sampled at edge k, and done is high in the cycle after edge k+N (k+17 for the default). done lasts exactly one cycle.
- start during RUN is ignored and has no effect on the operation in flight.
- start in the same cycle that done is high is accepted, because the state is already IDLE. The product outputs then hold until that next operation completes.
- productH and productL hold their last values between operations and never change while busy=1.
- Product result:
  - Unsigned: the exact unsigned 2P-bit product.
  - Signed: the exact signed 2P-bit product. -2^(P-1) * -2^(P-1) = 2^(2P-2) is representable and must be exact.
- Operand inputs may change freely after the start edge without affecting the result.
- Counter width is ceil(log2(N))+1 bits. It never wraps, because RUN exits at count = N-1.

Decomposition:
- Shared package mdu_pkg holds:
  - the state enum {IDLE, RUN};
  - the Booth digit enum {ZERO, POS1, POS2, NEG1, NEG2};
  - the function calculating N from parallelism.
- One sub-module, booth_pp_gen, is combinational. It takes the 3-bit triplet and the extended multiplicand, and outputs the sign-extended partial product plus the negate carry-in.
- The top level holds the FSM, counter, operand and accumulator registers, and the output registers.

Test Plan:
1. Unsigned 7 * 6 -> productH=0x00000000, productL=0x0000002A; done pulses exactly once, in the cycle after edge k+17; busy is high for 17 cycles.
2. Unsigned 0xFFFFFFFF * 0xFFFFFFFF -> productH=0xFFFFFFFE, productL=0x00000001. Signed 0xFFFFFFFF * 0xFFFFFFFF (-1 * -1) -> productH=0, productL=1.
3. Signed 0x80000000 * 0x80000000 -> productH=0x40000000, productL=0. Signed -3 * 5 -> productH=0xFFFFFFFF, productL=0xFFFFFFF1.
4. Start 2*3, then pulse start with 9*9 at RUN cycle 5 -> second request ignored; result 6; no second done. Then start while done=1 -> new operation accepted; previous product held until it completes.
5. Assert rst_n=0 at RUN cycle 8 -> busy, done, productH and productL all 0 immediately; no done pulse follows; a fresh 4*4 run afterwards gives 16 normally.
6. Randomised check of 1000 operand pairs in both modes against a 64-bit reference model, with operands changed after the start edge -> all results match.
